// File: rtl/vend_arbiter_if.sv
// Panel-side bus of the two-panel vending arbiter.
// coin_reject is combinational (same-cycle reject); all other outputs are registered.
interface vend_arbiter_if;
    logic [1:0] req;
    logic [1:0] prod_a;
    logic [1:0] prod_b;
    logic [1:0] coin5;
    logic [1:0] coin10;
    logic       restock;
    logic [1:0] gnt;
    logic       busy;
    logic       issue_prod;
    logic       not_available;
    logic       refund;
    logic [1:0] change5;
    logic [1:0] coin_reject;

    modport master (
        output req, prod_a, prod_b, coin5, coin10, restock,
        input  gnt, busy, issue_prod, not_available, refund, change5, coin_reject
    );

    modport slave (
        input  req, prod_a, prod_b, coin5, coin10, restock,
        output gnt, busy, issue_prod, not_available, refund, change5, coin_reject
    );
endinterface

// File: rtl/vend_arbiter.sv
// Two-panel round-robin vending arbiter with coin credit, inventory and refund.
// Optional idle-coin abort enabled by defining VEND_ARBITER_TIMEOUT_EN.
module vend_arbiter #(
    parameter int unsigned INIT_COUNT    = 2,
    parameter int unsigned RESTOCK_COUNT = 7,
    parameter int unsigned TIMEOUT_CYC   = 15
) (
    input logic          clk,
    input logic          rst_n,
    vend_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned NPROD  = 4;
    localparam int unsigned TMO_W  = 4;

    // The idle counter is 4 bits wide, so the timeout must fit in it.
    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_COLLECT, S_DISPENSE, S_REFUND
    } state_t;

    state_t                        state_q, state_d;
    logic                          panel_q, panel_d;
    logic                          ptr_q, ptr_d;
    logic [1:0]                    prod_q, prod_d;
    logic [CNT_W-1:0]              credit_q, credit_d;
    logic [NPROD-1:0][CNT_W-1:0]   inv_q, inv_d;
    logic [1:0]                    gnt_q, gnt_d;
    logic                          busy_q, busy_d;
    logic                          issue_q, issue_d;
    logic                          na_q, na_d;
    logic                          refund_q, refund_d;
    logic [1:0]                    change5_q, change5_d;
`ifdef VEND_ARBITER_TIMEOUT_EN
    logic [TMO_W-1:0]              tmo_q, tmo_d;
`endif

    logic             pick;
    logic [1:0]       add;
    logic [1:0]       accept;
    logic [CNT_W-1:0] cost;
    logic [1:0]       coin_reject_c;

    always_comb begin
        state_d       = state_q;
        panel_d       = panel_q;
        ptr_d         = ptr_q;
        prod_d        = prod_q;
        credit_d      = credit_q;
        inv_d         = inv_q;
        pick          = 1'b0;
        add           = 2'b00;
        accept        = 2'b00;
        cost          = CNT_W'(prod_q) + CNT_W'(1);
`ifdef VEND_ARBITER_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.restock) begin
                    for (int i = 0; i < int'(NPROD); i++) inv_d[i] = CNT_W'(RESTOCK_COUNT);
                end else if (|bus.req) begin
                    // Contention goes to the preferred panel; otherwise the lone requester.
                    pick     = (bus.req == 2'b11) ? ptr_q : bus.req[1];
                    panel_d  = pick;
                    ptr_d    = ~pick;
                    prod_d   = pick ? bus.prod_b : bus.prod_a;
                    credit_d = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (inv_q[prod_q] == '0) ? S_IDLE : S_COLLECT;
`ifdef VEND_ARBITER_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_COLLECT: begin
                if (!bus.req[panel_q]) begin
                    state_d = S_REFUND;
                end else begin
                    accept   = panel_q ? 2'b10 : 2'b01;
                    add      = {bus.coin10[panel_q], bus.coin5[panel_q]};
                    credit_d = credit_q + CNT_W'(add);
                    if (credit_d >= cost) state_d = S_DISPENSE;
`ifdef VEND_ARBITER_TIMEOUT_EN
                    if (add != 2'b00) begin
                        tmo_d = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                        if (tmo_d == TMO_W'(TIMEOUT_CYC)) state_d = S_REFUND;
                    end
`endif
                end
            end
            S_DISPENSE: begin
                inv_d[prod_q] = inv_q[prod_q] - CNT_W'(1);
                state_d       = S_IDLE;
            end
            S_REFUND: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d != S_IDLE);
        gnt_d     = busy_d ? (panel_d ? 2'b10 : 2'b01) : 2'b00;
        issue_d   = (state_d == S_DISPENSE);
        refund_d  = (state_d == S_REFUND);
        na_d      = (state_d == S_CHECK) && (inv_d[prod_d] == '0);
        change5_d = issue_d  ? 2'(credit_d - cost) :
                    refund_d ? 2'(credit_d) : 2'b00;
        coin_reject_c = (bus.coin5 | bus.coin10) & ~accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            panel_q   <= 1'b0;
            ptr_q     <= 1'b0;
            prod_q    <= 2'b00;
            credit_q  <= '0;
            for (int i = 0; i < int'(NPROD); i++) inv_q[i] <= CNT_W'(INIT_COUNT);
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            issue_q   <= 1'b0;
            na_q      <= 1'b0;
            refund_q  <= 1'b0;
            change5_q <= 2'b00;
`ifdef VEND_ARBITER_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            panel_q   <= panel_d;
            ptr_q     <= ptr_d;
            prod_q    <= prod_d;
            credit_q  <= credit_d;
            inv_q     <= inv_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            issue_q   <= issue_d;
            na_q      <= na_d;
            refund_q  <= refund_d;
            change5_q <= change5_d;
`ifdef VEND_ARBITER_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.busy          = busy_q;
    assign bus.issue_prod    = issue_q;
    assign bus.not_available = na_q;
    assign bus.refund        = refund_q;
    assign bus.change5       = change5_q;
    assign bus.coin_reject   = coin_reject_c;
endmodule

// File: tb/tb_vend_arbiter.sv
// Scoreboard bench for vend_arbiter: directed purchases, expected events queued, monitor compares.
module tb_vend_arbiter;
    localparam logic [2:0] K_ISSUE = 3'b100;
    localparam logic [2:0] K_NA    = 3'b010;
    localparam logic [2:0] K_REF   = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [1:0] ch;
        logic [1:0] gnt;
    } ev_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ev_t  exp_q[$];
    logic [1:0] rej_q[$];
    ev_t  mon_act, mon_exp;
    logic [1:0] rej_exp;

    vend_arbiter_if bus ();

    vend_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every event pulse and every coin reject must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.issue_prod || bus.not_available || bus.refund) begin
                mon_act = '{kind: {bus.issue_prod, bus.not_available, bus.refund},
                            ch: bus.change5, gnt: bus.gnt};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=%0h required=none at %0t", mon_act, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("event", {1'b0, mon_act}, {1'b0, mon_exp});
                end
            end else if (bus.change5 != 2'b00) begin
                chk("change5_idle", {6'd0, bus.change5}, 8'd0);
            end
            if (bus.coin_reject != 2'b00) begin
                if (rej_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_reject actual=%0h required=none at %0t", bus.coin_reject, $time);
                end else begin
                    rej_exp = rej_q.pop_front();
                    chk("coin_reject", {6'd0, bus.coin_reject}, {6'd0, rej_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request and advance through IDLE->CHECK->COLLECT.
    task automatic start(input logic [1:0] r, input logic [1:0] pa, input logic [1:0] pb);
        bus.req    = r;
        bus.prod_a = pa;
        bus.prod_b = pb;
        tick();
        tick();
    endtask

    task automatic coin(input logic [1:0] c5, input logic [1:0] c10);
        bus.coin5  = c5;
        bus.coin10 = c10;
        tick();
        bus.coin5  = 2'b00;
        bus.coin10 = 2'b00;
    endtask

    task automatic finish_txn();
        bus.req = 2'b00;
        tick();
    endtask

    task automatic push(input logic [2:0] k, input logic [1:0] c, input logic [1:0] g);
        exp_q.push_back('{kind: k, ch: c, gnt: g});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n       = 1'b0;
        bus.req     = 2'b00;
        bus.prod_a  = 2'b00;
        bus.prod_b  = 2'b00;
        bus.coin5   = 2'b00;
        bus.coin10  = 2'b00;
        bus.restock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",     {6'd0, bus.gnt}, 8'd0);
        chk("rst_busy",    {7'd0, bus.busy}, 8'd0);
        chk("rst_issue",   {7'd0, bus.issue_prod}, 8'd0);
        chk("rst_na",      {7'd0, bus.not_available}, 8'd0);
        chk("rst_refund",  {7'd0, bus.refund}, 8'd0);
        chk("rst_change5", {6'd0, bus.change5}, 8'd0);
        chk("rst_reject",  {6'd0, bus.coin_reject}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Product 0 on A with one coin5: exact payment.
        push(K_ISSUE, 2'd0, 2'b01);
        start(2'b01, 2'd0, 2'd0);
        coin(2'b01, 2'b00);
        finish_txn();

        // Product 3 with 10+10; panel product change mid-collect must be ignored.
        push(K_ISSUE, 2'd0, 2'b01);
        start(2'b01, 2'd3, 2'd0);
        bus.prod_a = 2'd0;
        coin(2'b00, 2'b01);
        coin(2'b00, 2'b01);
        finish_txn();

        // Product 2 with 10+10: one 5 back.
        push(K_ISSUE, 2'd1, 2'b01);
        start(2'b01, 2'd2, 2'd0);
        coin(2'b00, 2'b01);
        coin(2'b00, 2'b01);
        finish_txn();

        // B's coin rejected during A's collect, then A walks away with 5 in credit.
        rej_q.push_back(2'b10);
        push(K_REF, 2'd1, 2'b01);
        start(2'b01, 2'd1, 2'd0);
        coin(2'b00, 2'b10);
        coin(2'b01, 2'b00);
        bus.req = 2'b00;
        tick();
        tick();

        // Product 1 sells out after two purchases; a CHECK-time coin is rejected.
        rej_q.push_back(2'b01);
        push(K_ISSUE, 2'd0, 2'b01);
        bus.req    = 2'b01;
        bus.prod_a = 2'd1;
        tick();
        coin(2'b01, 2'b00);
        coin(2'b00, 2'b01);
        finish_txn();
        push(K_ISSUE, 2'd0, 2'b01);
        start(2'b01, 2'd1, 2'd0);
        coin(2'b00, 2'b01);
        finish_txn();
        push(K_NA, 2'd0, 2'b01);
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        chk("soldout_gnt_release", {6'd0, bus.gnt}, 8'd0);

        // Restock beats a simultaneous request, then the purchase succeeds (5+10 for 10).
        bus.restock = 1'b1;
        bus.req     = 2'b01;
        tick();
        bus.restock = 1'b0;
        chk("restock_no_busy", {7'd0, bus.busy}, 8'd0);
        chk("restock_no_gnt",  {6'd0, bus.gnt}, 8'd0);
        tick();
        tick();
        push(K_ISSUE, 2'd1, 2'b01);
        coin(2'b01, 2'b01);
        finish_txn();

        // Reset mid-collect drops the credit silently.
        start(2'b01, 2'd3, 2'd0);
        coin(2'b00, 2'b01);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        tick();
        chk("midrst_busy", {7'd0, bus.busy}, 8'd0);
        chk("midrst_gnt",  {6'd0, bus.gnt}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Both panels from reset: A first, then B while A still requests.
        push(K_ISSUE, 2'd0, 2'b01);
        push(K_ISSUE, 2'd0, 2'b10);
        start(2'b11, 2'd0, 2'd1);
        chk("rr_first_gnt", {6'd0, bus.gnt}, 8'h01);
        coin(2'b01, 2'b00);
        tick();
        tick();
        chk("rr_second_gnt", {6'd0, bus.gnt}, 8'h02);
        tick();
        coin(2'b00, 2'b10);
        finish_txn();

        // Idle after one coin: timeout refund if enabled, otherwise waits until req drops.
        push(K_REF, 2'd1, 2'b01);
        start(2'b01, 2'd3, 2'd0);
        coin(2'b01, 2'b00);
`ifdef VEND_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 40 && !bus.refund; i++) tick();
        bus.req = 2'b00;
        tick();
`else
        repeat (20) tick();
        chk("no_timeout_busy", {7'd0, bus.busy}, 8'd1);
        bus.req = 2'b00;
        tick();
        tick();
`endif

        repeat (3) tick();
        chk("exp_queue_drained", 8'(exp_q.size()), 8'd0);
        chk("rej_queue_drained", 8'(rej_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter INIT_COUNT, default 2: per-product stock loaded at reset.
REQ-003 Parameter RESTOCK_COUNT, default 7: per-product stock loaded on restock.
REQ-004 Parameter TIMEOUT_CYC, default 15: idle-coin cycles before abort (TIMEOUT_EN only).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 req  in  2  per-panel purchase request, bit0 = panel A, bit1 = panel B; level, held for the whole transaction.
REQ-008 prod_a, prod_b  in  2 each  product selected at panel A and panel B.
REQ-009 coin5, coin10  in  2 each  one-cycle coin pulses per panel.
REQ-010 restock  in  1  one-cycle pulse that refills inventory.
REQ-011 gnt  out  2  one-hot grant to the panel being served.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 issue_prod  out  1  one-cycle dispense pulse.
REQ-014 not_available  out  1  one-cycle sold-out pulse.
REQ-015 refund  out  1  one-cycle refund pulse.
REQ-016 change5  out  2  count of 5-unit coins returned, valid with issue_prod or refund; 0 otherwise.
REQ-017 coin_reject  out  2  per-panel pulse, same cycle, for a coin that was not accepted.

Function
REQ-018 The cost table SHALL be fixed: product p costs p+1 units of 5 (5, 10, 15, 20); credit SHALL be a 3-bit count of units.
REQ-019 Inventory SHALL be four 3-bit counters.
REQ-020 The state machine SHALL use the states IDLE, CHECK, COLLECT, DISPENSE and REFUND.
REQ-021 IDLE with restock=1: all counters SHALL load RESTOCK_COUNT, with no grant that cycle; restock SHALL be ignored in every other state.
REQ-022 IDLE with any req (and no restock): the block SHALL grant, latch the selected panel's product, clear credit and go to CHECK.
REQ-023 If both panels request, the block SHALL grant the panel not granted last; the round-robin pointer SHALL update on every grant.
REQ-024 CHECK with the latched product's count = 0: not_available=1 for that cycle, gnt released next cycle, return to IDLE.
REQ-025 CHECK with count > 0: the block SHALL go to COLLECT.
REQ-026 COLLECT: coin5 from the granted panel SHALL add 1 unit, coin10 SHALL add 2, and both in the same cycle SHALL add 3.
REQ-027 When updated credit >= cost, the next state SHALL be DISPENSE.
REQ-028 Coins from the non-granted panel, and any coin outside COLLECT, SHALL give coin_reject for that panel in the same cycle and SHALL NOT change credit.
REQ-029 DISPENSE (one cycle): issue_prod=1, change5 = credit - cost (at most 2), count decremented by 1, then IDLE.
REQ-030 COLLECT with the granted panel's req deasserted: the block SHALL go to REFUND; a coin in that same cycle SHALL be rejected.
REQ-031 REFUND (one cycle): refund=1, change5 = credit, then IDLE.
REQ-032 gnt SHALL stay asserted from the cycle after the IDLE grant decision through the DISPENSE, REFUND or sold-out CHECK cycle.
REQ-033 A product is not looked up again after CHECK; prod_* changes during COLLECT SHALL be ignored.

Reset
REQ-034 Reset SHALL force IDLE, gnt=0, busy=0, issue_prod=0, not_available=0, refund=0, change5=0, coin_reject=0, credit=0, pointer = panel A preferred, and all counters = INIT_COUNT.
REQ-035 Reset asserted mid-transaction SHALL discard credit with no refund pulse.

Configuration
REQ-036 Macro VEND_ARBITER_TIMEOUT_EN defined: a 4-bit counter SHALL run in COLLECT, clear on each accepted coin, and go to REFUND when it reaches TIMEOUT_CYC.
REQ-037 Macro VEND_ARBITER_TIMEOUT_EN undefined: COLLECT SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-038 After reset: req=01, prod_a=0, coin5 on A -> issue_prod=1, change5=0, count[0]=1.
REQ-039 req=11 simultaneously from reset -> A granted first; after A completes, B granted although A is still requesting.
REQ-040 prod=3, coins 10,10 -> DISPENSE, change5=0; prod=2, coins 10,10 -> change5=1.
REQ-041 Buy product 1 three times with INIT_COUNT=2 -> third attempt gives not_available pulse and no issue_prod; restock in IDLE -> next purchase succeeds.
REQ-042 During A's COLLECT, coin10 on B -> coin_reject=10, A's credit unchanged; A drops req after coin5 -> refund=1, change5=1.
REQ-043 With VEND_ARBITER_TIMEOUT_EN: no coin for 15 cycles after one coin5 -> refund, change5=1; without the macro -> stays in COLLECT.
